feed_sequencer: RTL and testbench

FEED_SEQUENCER -- requirements
Module: feed_sequencer

---
 rtl/feed_sequencer.sv | 171 +++++++++++++++++
 tb/tb_feed_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_sequencer.sv
// Arbitrates two redundant market-data feeds (A/B) into one gap-free, in-order stream.
// Duplicates are dropped, and a missing sequence number is skipped after GAP_TIMEOUT stalled cycles.
module feed_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid_i,
    input  logic [167:0] a_msg_i,
    output logic         a_ready_o,
    input  logic         b_valid_i,
    input  logic [167:0] b_msg_i,
    output logic         b_ready_o,
    output logic         out_valid_o,
    output logic [167:0] out_msg_o,
    input  logic         out_ready_i,
    output logic [31:0]  expected_seq_o,
    output logic [15:0]  dup_count_o,
    output logic [15:0]  gap_count_o,
    output logic         gap_active_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_GAP    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        exp_q, exp_d;
    logic [15:0]        dup_q, dup_d;
    logic [15:0]        gap_q, gap_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [167:0]       mem_q [FIFO_DEPTH];

    logic [31:0]  a_seq, b_seq, min_ahead_seq;
    logic         full, empty;
    logic         a_acc, b_acc, a_hit, b_hit, a_dup, b_dup;
    logic         a_ahead, b_ahead, any_ahead;
    logic         push, pop;
    logic [167:0] push_msg;
    logic [1:0]   dup_inc;
    logic [16:0]  dup_sum, gap_sum;

    assign a_seq = a_msg_i[39:8];
    assign b_seq = b_msg_i[39:8];

    // Fullness comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    assign a_ready_o = !rst && !full && (!a_valid_i || (a_seq <= exp_q));
    assign b_ready_o = !rst && !full && (!b_valid_i || (b_seq <= exp_q));

    assign a_acc = a_valid_i && a_ready_o;
    assign b_acc = b_valid_i && b_ready_o;
    assign a_hit = a_acc && (a_seq == exp_q);
    assign b_hit = b_acc && (b_seq == exp_q);
    assign a_dup = a_acc && (a_seq < exp_q);
    assign b_dup = b_acc && (b_seq < exp_q);

    // A wins a same-cycle tie; B's copy then counts as a duplicate.
    assign push     = a_hit || b_hit;
    assign push_msg = a_hit ? a_msg_i : b_msg_i;
    assign dup_inc  = {1'b0, a_dup} + {1'b0, b_dup} + {1'b0, a_hit && b_hit};
    assign dup_sum  = {1'b0, dup_q} + {15'd0, dup_inc};
    assign gap_sum  = {1'b0, gap_q} + 17'd1;

    assign a_ahead   = a_valid_i && (a_seq > exp_q);
    assign b_ahead   = b_valid_i && (b_seq > exp_q);
    assign any_ahead = a_ahead || b_ahead;

    always_comb begin
        min_ahead_seq = b_seq;
        if (a_ahead && b_ahead) begin
            min_ahead_seq = (a_seq < b_seq) ? a_seq : b_seq;
        end else if (a_ahead) begin
            min_ahead_seq = a_seq;
        end
    end

    assign out_valid_o    = !rst && !empty;
    assign out_msg_o      = mem_q[rd_ptr_q];
    assign pop            = out_valid_o && out_ready_i;
    assign expected_seq_o = exp_q;
    assign dup_count_o    = dup_q;
    assign gap_count_o    = gap_q;
    assign gap_active_o   = !rst && (state_q == ST_GAP);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        exp_d   = push ? exp_q + 32'd1 : exp_q;
        dup_d   = dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
        unique case (state_q)
            ST_NORMAL: begin
                if (!full && !push && any_ahead) begin
                    state_d = ST_GAP;
                    timer_d = TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (push || !any_ahead) begin
                    state_d = ST_NORMAL;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(GAP_TIMEOUT)) begin
                    // Give up on the missing numbers; the ahead message is taken next cycle.
                    exp_d   = min_ahead_seq;
                    gap_d   = gap_sum[16] ? 16'hFFFF : gap_sum[15:0];
                    state_d = ST_NORMAL;
                    timer_d = '0;
                end else if (!full) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_NORMAL;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NORMAL;
            timer_q  <= '0;
            exp_q    <= '0;
            dup_q    <= '0;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            exp_q   <= exp_d;
            dup_q   <= dup_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_msg;
        end
    end

endmodule

// File: tb/tb_feed_sequencer.sv
// Bench for feed_sequencer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized redundant-feed traffic.
module tb_feed_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, a_ready, b_ready;
    logic [167:0] a_msg, b_msg, out_msg;
    logic         out_valid, out_ready, gap_active;
    logic [31:0]  expected_seq;
    logic [15:0]  dup_count, gap_count;

    feed_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid_i      (a_valid),
        .a_msg_i        (a_msg),
        .a_ready_o      (a_ready),
        .b_valid_i      (b_valid),
        .b_msg_i        (b_msg),
        .b_ready_o      (b_ready),
        .out_valid_o    (out_valid),
        .out_msg_o      (out_msg),
        .out_ready_i    (out_ready),
        .expected_seq_o (expected_seq),
        .dup_count_o    (dup_count),
        .gap_count_o    (gap_count),
        .gap_active_o   (gap_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: forwarded messages awaiting output, plus sequencing state.
    logic [167:0] exp_q[$];
    logic [31:0]  m_exp;
    int           m_dup, m_gap, m_timer;
    bit           m_in_gap;
    logic [31:0]  obs_q[$];

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [167:0] mk(input logic [31:0] seq, input logic [7:0] tag);
        logic [167:0] m;
        m[167:40] = {$urandom(), $urandom(), $urandom(), $urandom()};
        m[39:8]   = seq;
        m[7:0]    = tag;
        return m;
    endfunction

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic tick(input logic r, input logic av, input logic [167:0] am,
                        input logic bv, input logic [167:0] bm, input logic ordy,
                        output bit acc_a, output bit acc_b);
        logic [31:0] as, bs, mn;
        bit full_m, ra, rb, ov, ahit, bhit, adup, bdup, a_ah, b_ah, pushed;
        @(negedge clk);
        rst = r; a_valid = av; a_msg = am; b_valid = bv; b_msg = bm; out_ready = ordy;
        #1;
        as = am[39:8];
        bs = bm[39:8];
        full_m = (exp_q.size() == DEPTH);
        ra = !r && !full_m && (!av || as <= m_exp);
        rb = !r && !full_m && (!bv || bs <= m_exp);
        ov = !r && (exp_q.size() > 0);
        acc_a = av && ra;
        acc_b = bv && rb;
        chk("a_ready", a_ready, ra);
        chk("b_ready", b_ready, rb);
        chk("out_valid", out_valid, ov);
        chk("gap_active", gap_active, !r && m_in_gap);
        if (r) begin
            exp_q.delete();
            m_exp = '0; m_dup = 0; m_gap = 0; m_timer = 0; m_in_gap = 0;
            return;
        end
        if (ov) chk("out_msg", out_msg, exp_q[0]);
        chk("expected_seq", expected_seq, m_exp);
        chk("dup_count", dup_count, m_dup[15:0]);
        chk("gap_count", gap_count, m_gap[15:0]);
        if (out_valid && ordy) obs_q.push_back(out_msg[39:8]);
        if (ov && ordy) void'(exp_q.pop_front());
        ahit = acc_a && as == m_exp;
        bhit = acc_b && bs == m_exp;
        adup = acc_a && as < m_exp;
        bdup = acc_b && bs < m_exp;
        pushed = ahit || bhit;
        if (ahit) exp_q.push_back(am);
        else if (bhit) exp_q.push_back(bm);
        m_dup = m_dup + int'(adup) + int'(bdup) + int'(ahit && bhit);
        if (m_dup > 65535) m_dup = 65535;
        a_ah = av && as > m_exp;
        b_ah = bv && bs > m_exp;
        mn = (a_ah && b_ah) ? ((as < bs) ? as : bs) : (a_ah ? as : bs);
        if (pushed) m_exp = m_exp + 32'd1;
        if (!m_in_gap) begin
            if (!full_m && !pushed && (a_ah || b_ah)) begin
                m_in_gap = 1; m_timer = 1;
            end
        end else if (pushed || !(a_ah || b_ah)) begin
            m_in_gap = 0; m_timer = 0;
        end else if (m_timer == TMO) begin
            m_exp = mn;
            m_gap = (m_gap < 65535) ? m_gap + 1 : 65535;
            m_in_gap = 0; m_timer = 0;
        end else if (!full_m) begin
            m_timer++;
        end
    endtask

    task automatic idle(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, x, y);
    endtask

    task automatic do_reset();
        bit x, y;
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, x, y);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, x, y);
        obs_q.delete();
    endtask

    // Hold A valid with m (B idle) until accepted; waited = index of the accepting cycle.
    task automatic run_a(input logic [167:0] m, input logic ordy, input int budget, output int waited);
        bit aa, bb;
        waited = budget;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b1, m, 1'b0, '0, ordy, aa, bb);
            if (aa) begin
                waited = i;
                return;
            end
        end
        chk("accept_budget", aa, 1'b1);
    endtask

    task automatic chk_obs(input string name, input logic [31:0] want[$]);
        logic [31:0] got;
        chk({name, "_count"}, obs_q.size(), want.size());
        foreach (want[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 32'hDEADBEEF;
            chk(name, got, want[i]);
        end
    endtask

    initial begin
        bit aa, bb, av_h, bv_h;
        int w, cyc;
        logic [167:0] m0, m1, m2, mb;
        logic [167:0] a_src[$], b_src[$];

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_msg = '0; b_msg = '0; out_ready = 1'b0;

        // Reset outputs
        do_reset();
        idle(1);
        chk("rst_exp", expected_seq, 32'd0);
        chk("rst_dup", dup_count, 16'd0);

        // A then B one cycle later carrying the same 0,1,2
        do_reset();
        m0 = mk(0, 8'hA0); m1 = mk(1, 8'hA1); m2 = mk(2, 8'hA2);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        tick(1'b0, 1'b1, m1, 1'b1, m0, 1'b1, aa, bb);
        tick(1'b0, 1'b1, m2, 1'b1, m1, 1'b1, aa, bb);
        tick(1'b0, 1'b0, '0, 1'b1, m2, 1'b1, aa, bb);
        idle(3);
        chk("dual_dup", dup_count, 16'd3);
        chk("dual_exp", expected_seq, 32'd3);
        chk_obs("dual_order", '{32'd0, 32'd1, 32'd2});

        // Tie on seq 0: A forwarded, B dropped
        do_reset();
        m0 = mk(0, 8'hAA); mb = mk(0, 8'hBB);
        tick(1'b0, 1'b1, m0, 1'b1, mb, 1'b0, aa, bb);
        tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, aa, bb);
        chk("tie_out_msg", out_msg, m0);
        chk("tie_dup", dup_count, 16'd1);
        chk("tie_exp", expected_seq, 32'd1);

        // Gap skip: expected 3, A shows 5
        do_reset();
        for (int s = 0; s < 3; s++) run_a(mk(s, 8'h11), 1'b1, 4, w);
        m0 = mk(5, 8'h55);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        chk("gap_a_ready", a_ready, 1'b0);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        chk("gap_active_on", gap_active, 1'b1);
        run_a(m0, 1'b1, 40, w);
        chk("gap_accept_cycle", w, 15);
        chk("gap_skip_exp", expected_seq, 32'd5);
        chk("gap_skip_count", gap_count, 16'd1);
        idle(3);
        chk("gap_skip_exp_after", expected_seq, 32'd6);
        chk_obs("gap_order", '{32'd0, 32'd1, 32'd2, 32'd5});

        // Late fill inside GAP at timer 4
        do_reset();
        for (int s = 0; s < 3; s++) run_a(mk(s, 8'h22), 1'b1, 4, w);
        m0 = mk(4, 8'h44); mb = mk(3, 8'h33);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        tick(1'b0, 1'b1, m0, 1'b1, mb, 1'b1, aa, bb);
        chk("fill_gap_active", gap_active, 1'b1);
        chk("fill_b_ready", b_ready, 1'b1);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        chk("fill_gap_off", gap_active, 1'b0);
        chk("fill_a_ready", a_ready, 1'b1);
        chk("fill_gap_count", gap_count, 16'd0);
        idle(3);
        chk_obs("fill_order", '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4});

        // Backpressure: FIFO fills at 4, seq 4 held, then drained in order
        do_reset();
        for (int s = 0; s < 4; s++) begin
            tick(1'b0, 1'b1, mk(s, 8'h66), 1'b0, '0, 1'b0, aa, bb);
            chk("bp_accept", aa, 1'b1);
        end
        m0 = mk(4, 8'h66);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b0, aa, bb);
        chk("bp_full_ready", a_ready, 1'b0);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        chk("bp_pop_cycle_ready", a_ready, 1'b0);
        run_a(m0, 1'b1, 10, w);
        chk("bp_accept_next", w, 0);
        idle(8);
        chk_obs("bp_order", '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4});

        // Reset in the middle of GAP with two messages buffered
        do_reset();
        tick(1'b0, 1'b1, mk(0, 8'h77), 1'b0, '0, 1'b0, aa, bb);
        tick(1'b0, 1'b1, mk(1, 8'h77), 1'b0, '0, 1'b0, aa, bb);
        m0 = mk(9, 8'h99);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b0, aa, bb);
        tick(1'b0, 1'b1, m0, 1'b0, '0, 1'b0, aa, bb);
        chk("mid_gap_active", gap_active, 1'b1);
        chk("mid_out_valid", out_valid, 1'b1);
        tick(1'b1, 1'b1, m0, 1'b0, '0, 1'b1, aa, bb);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, aa, bb);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_gap", gap_active, 1'b0);
        chk("post_rst_exp", expected_seq, 32'd0);
        chk("post_rst_dup", dup_count, 16'd0);
        chk("post_rst_gapcnt", gap_count, 16'd0);

        // Sequence number wrap through 0xFFFFFFFF
        do_reset();
        run_a(mk(32'hFFFFFFFE, 8'hE0), 1'b1, 40, w);
        run_a(mk(32'hFFFFFFFF, 8'hE1), 1'b1, 4, w);
        chk("wrap_exp_zero", expected_seq, 32'hFFFFFFFF);
        run_a(mk(32'd0, 8'hE2), 1'b1, 4, w);
        chk("wrap_accept_zero", w, 0);
        idle(4);
        chk("wrap_exp", expected_seq, 32'd1);
        chk_obs("wrap_order", '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0});

        // Randomized redundant feeds with losses on either side and stale replays
        do_reset();
        for (int s = 0; s < 300; s++) begin
            m0 = mk(s, 8'hA1);
            if ($urandom_range(0, 99) < 85) a_src.push_back(m0);
            if ($urandom_range(0, 99) < 85) b_src.push_back(m0 ^ 168'hFF);
            if (s >= 4 && $urandom_range(0, 99) < 8) b_src.push_back(mk(s - 3, 8'hB7));
        end
        av_h = 0; bv_h = 0; cyc = 0;
        while ((a_src.size() > 0 || b_src.size() > 0) && cyc < 20000) begin
            if (!av_h && a_src.size() > 0 && $urandom_range(0, 9) < 7) av_h = 1;
            if (!bv_h && b_src.size() > 0 && $urandom_range(0, 9) < 7) bv_h = 1;
            m0 = av_h ? a_src[0] : '0;
            m1 = bv_h ? b_src[0] : '0;
            tick(1'b0, av_h, m0, bv_h, m1, $urandom_range(0, 3) != 0, aa, bb);
            if (aa) begin void'(a_src.pop_front()); av_h = 0; end
            if (bb) begin void'(b_src.pop_front()); bv_h = 0; end
            cyc++;
        end
        chk("random_drained", a_src.size() + b_src.size(), 0);
        idle(10);

        // dup_count saturation with both feeds replaying seq 0
        do_reset();
        run_a(mk(0, 8'hC0), 1'b1, 4, w);
        m0 = mk(0, 8'hC1); mb = mk(0, 8'hC2);
        for (int i = 0; i < 32800; i++) tick(1'b0, 1'b1, m0, 1'b1, mb, 1'b1, aa, bb);
        idle(1);
        chk("dup_saturate", dup_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
